// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Request/response channels and TotalALU drive/return signals
//               shared by the ALU operation sequencer and its requester.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [5:0]  alu_signal;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        busy;

    modport slave (
        input  req_valid, req_funct, req_a, req_b, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_data, rsp_err, alu_signal, alu_a, alu_b, busy
    );

    modport master (
        output req_valid, req_funct, req_a, req_b, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_data, rsp_err, alu_signal, alu_a, alu_b, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Issues one operation at a time to TotalALU, stretches DIVU
//               over the divider latency and returns the captured result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    alu_op_sequencer_if.slave     bus
);

    localparam logic [5:0] c_fn_and  = 6'd36;
    localparam logic [5:0] c_fn_or   = 6'd37;
    localparam logic [5:0] c_fn_add  = 6'd32;
    localparam logic [5:0] c_fn_sub  = 6'd34;
    localparam logic [5:0] c_fn_srl  = 6'd2;
    localparam logic [5:0] c_fn_slt  = 6'd42;
    localparam logic [5:0] c_fn_divu = 6'd27;
    localparam logic [5:0] c_fn_mfhi = 6'd16;
    localparam logic [5:0] c_fn_mflo = 6'd18;
    localparam logic [5:0] c_div_last = 6'(DIV_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXEC      = 3'd1,
        ST_DIV_RUN   = 3'd2,
        ST_DIV_LATCH = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  signal_q, signal_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        w_req_ready;
    logic        w_accept;
    logic        w_single;

    // Held low while reset is asserted so nothing is offered as accepted.
    assign w_req_ready = (state_q == ST_IDLE) && reset;
    assign w_accept    = bus.req_valid && w_req_ready;

    always_comb begin
        w_single = 1'b0;
        case (bus.req_funct)
            c_fn_and, c_fn_or, c_fn_add, c_fn_sub, c_fn_srl,
            c_fn_slt, c_fn_mfhi, c_fn_mflo: w_single = 1'b1;
            default:                        w_single = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            signal_q <= 6'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            cnt_q    <= 6'd0;
            data_q   <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            signal_q <= signal_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        signal_d = signal_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    a_d = bus.req_a;
                    b_d = bus.req_b;
                    if (bus.req_funct == c_fn_divu) begin
                        signal_d = c_fn_divu;
                        cnt_d    = 6'd1;
                        state_d  = ST_DIV_RUN;
                    end else if (w_single) begin
                        signal_d = bus.req_funct;
                        state_d  = ST_EXEC;
                    end else begin
                        // Illegal code: the datapath is never driven.
                        signal_d = 6'd0;
                        data_d   = 32'd0;
                        err_d    = 1'b1;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                data_d   = bus.alu_result;
                err_d    = 1'b0;
                signal_d = 6'd0;
                state_d  = ST_RESP;
            end
            ST_DIV_RUN: begin
                if (cnt_q == c_div_last) begin
                    state_d = ST_DIV_LATCH;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_DIV_LATCH: begin
                // Extra DIVU cycle lets HiLo capture quotient and remainder.
                data_d   = 32'd0;
                err_d    = 1'b0;
                signal_d = 6'd0;
                cnt_d    = 6'd0;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_data   = data_q;
    assign bus.rsp_err    = err_q;
    assign bus.alu_signal = signal_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Directed self-checking bench with a behavioural TotalALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] hi_r = 32'd0;
    logic [31:0] lo_r = 32'd0;

    always #5 clk = ~clk;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.DIV_CYCLES(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural TotalALU: combinational result, HiLo written while DIVU is driven.
    always_comb begin
        bus.alu_result = 32'd0;
        case (bus.alu_signal)
            6'd36:   bus.alu_result = bus.alu_a & bus.alu_b;
            6'd37:   bus.alu_result = bus.alu_a | bus.alu_b;
            6'd32:   bus.alu_result = bus.alu_a + bus.alu_b;
            6'd34:   bus.alu_result = bus.alu_a - bus.alu_b;
            6'd2:    bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            6'd42:   bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            6'd16:   bus.alu_result = hi_r;
            6'd18:   bus.alu_result = lo_r;
            default: bus.alu_result = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.alu_signal == 6'd27 && bus.alu_b != 32'd0) begin
            hi_r <= bus.alu_a % bus.alu_b;
            lo_r <= bus.alu_a / bus.alu_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd32;
        bus.req_a     = 32'd1;
        bus.req_b     = 32'd1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_req_ready cyc%0d: got %b expected 0", i, bus.req_ready);
            end
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_rsp_valid cyc%0d: got %b expected 0", i, bus.rsp_valid);
            end
            checks++;
            if (bus.alu_signal !== 6'd0 || bus.rsp_data !== 32'd0 || bus.rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: sig=%0d data=%h err=%b expected 0/0/0",
                         i, bus.alu_signal, bus.rsp_data, bus.rsp_err);
            end
        end
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        tick();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req_ready=%b busy=%b expected 1/0", bus.req_ready, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd32;
        bus.req_a     = 32'd7;
        bus.req_b     = 32'd5;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.alu_signal !== 6'd32 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: sig=%0d rsp_valid=%b req_ready=%b expected 32/0/0",
                     bus.alu_signal, bus.rsp_valid, bus.req_ready);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd12 || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL add_resp: valid=%b data=%h err=%b expected 1/0000000c/0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_err);
        end
        checks++;
        if (bus.alu_signal !== 6'd0) begin
            errors++;
            $display("FAIL add_signal_one_cycle: got %0d expected 0", bus.alu_signal);
        end
        tick();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_done: req_ready=%b rsp_valid=%b expected 1/0", bus.req_ready, bus.rsp_valid);
        end
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd34;
        bus.req_a     = 32'd5;
        bus.req_b     = 32'd7;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.alu_signal !== 6'd34) begin
            errors++;
            $display("FAIL sub_exec: sig=%0d expected 34", bus.alu_signal);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hFFFF_FFFE || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL sub_resp: valid=%b data=%h err=%b expected 1/fffffffe/0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_err);
        end
        tick();
    endtask

    task automatic test_divide();
        int cycles;
        int n27;
        bit ready_seen;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd27;
        bus.req_a     = 32'd100;
        bus.req_b     = 32'd7;
        tick();
        bus.req_valid = 1'b0;
        cycles     = 1;
        n27        = 0;
        ready_seen = 1'b0;
        while (bus.rsp_valid !== 1'b1 && cycles < 100) begin
            if (bus.alu_signal === 6'd27) n27++;
            if (bus.req_ready !== 1'b0) ready_seen = 1'b1;
            tick();
            cycles++;
        end
        checks++;
        if (cycles != 34) begin
            errors++;
            $display("FAIL divu_latency: got %0d cycles expected 34", cycles);
        end
        checks++;
        if (n27 != 33) begin
            errors++;
            $display("FAIL divu_signal_cycles: got %0d expected 33", n27);
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL divu_req_ready: got 1 during divide expected 0");
        end
        checks++;
        if (bus.rsp_data !== 32'd0 || bus.rsp_err !== 1'b0 || bus.alu_signal !== 6'd0) begin
            errors++;
            $display("FAIL divu_resp: data=%h err=%b sig=%0d expected 0/0/0",
                     bus.rsp_data, bus.rsp_err, bus.alu_signal);
        end
        tick();
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd18;
        tick();
        bus.req_valid = 1'b0;
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd14) begin
            errors++;
            $display("FAIL mflo: valid=%b data=%0d expected 1/14", bus.rsp_valid, bus.rsp_data);
        end
        tick();
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd16;
        tick();
        bus.req_valid = 1'b0;
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd2) begin
            errors++;
            $display("FAIL mfhi: valid=%b data=%0d expected 1/2", bus.rsp_valid, bus.rsp_data);
        end
        tick();
    endtask

    task automatic test_illegal();
        logic [5:0] codes [2];
        codes[0] = 6'd63;
        codes[1] = 6'd0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.req_valid = 1'b1;
            bus.req_funct = codes[i];
            bus.req_a     = 32'h1234_5678;
            bus.req_b     = 32'h9ABC_DEF0;
            tick();
            bus.req_valid = 1'b0;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'd0) begin
                errors++;
                $display("FAIL illegal_resp funct=%0d: valid=%b err=%b data=%h expected 1/1/0",
                         codes[i], bus.rsp_valid, bus.rsp_err, bus.rsp_data);
            end
            checks++;
            if (bus.alu_signal !== 6'd0) begin
                errors++;
                $display("FAIL illegal_signal funct=%0d: got %0d expected 0", codes[i], bus.alu_signal);
            end
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.alu_signal !== 6'd0 || bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal_done funct=%0d: valid=%b sig=%0d ready=%b expected 0/0/1",
                         codes[i], bus.rsp_valid, bus.alu_signal, bus.req_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd42;
        bus.req_a     = 32'hFFFF_FFFF;
        bus.req_b     = 32'd1;
        tick();
        // Keep presenting a different request; it must be ignored while busy.
        bus.req_funct = 6'd37;
        bus.req_a     = 32'hAAAA_0000;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd1 || bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL slt_hold cyc%0d: valid=%b data=%h ready=%b expected 1/00000001/0",
                         i, bus.rsp_valid, bus.rsp_data, bus.req_ready);
            end
            tick();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd1) begin
            errors++;
            $display("FAIL slt_handshake: valid=%b data=%h expected 1/00000001", bus.rsp_valid, bus.rsp_data);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL slt_done: valid=%b ready=%b expected 0/1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset_mid_divide();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd27;
        bus.req_a     = 32'd50;
        bus.req_b     = 32'd3;
        tick();
        bus.req_valid = 1'b0;
        // Counter reads 1 now; nine more cycles bring it to 10.
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (bus.alu_signal !== 6'd27 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_div_running: sig=%0d busy=%b expected 27/1", bus.alu_signal, bus.busy);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.alu_signal !== 6'd0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_div_reset: busy=%b sig=%0d valid=%b expected 0/0/0",
                     bus.busy, bus.alu_signal, bus.rsp_valid);
        end
        reset = 1'b1;
        tick();
        bus.req_valid = 1'b1;
        bus.req_funct = 6'd37;
        bus.req_a     = 32'h0000_00F0;
        bus.req_b     = 32'h0000_000F;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.alu_signal !== 6'd37) begin
            errors++;
            $display("FAIL or_exec: valid=%b sig=%0d expected 0/37", bus.rsp_valid, bus.alu_signal);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_00FF || bus.rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL or_resp: valid=%b data=%h err=%b expected 1/000000ff/0",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_err);
        end
        tick();
    endtask

    initial begin
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_funct = 6'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_divide();
        test_illegal();
        test_backpressure();
        test_reset_mid_divide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
